// File: rtl/crypt_round_sequencer_pkg.sv
// crypt_pkg: shared types and constants for the round sequencer.
// Defines the per-byte op encoding, FSM states and block geometry.
package crypt_pkg;

    localparam int BLOCK_W = 32;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        OP_INV   = 2'b00,
        OP_ROR2  = 2'b01,
        OP_ROL2  = 2'b10,
        OP_INVLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

endpackage

// File: rtl/crypt_round_sequencer_if.sv
// crypt_round_sequencer_if: block-in / block-out valid-ready bundle.
// master = block source + result sink side, slave = sequencer side.
interface crypt_round_sequencer_if #(
    parameter int KEY_W = 10
);
    import crypt_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic [KEY_W-1:0]   in_key;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/crypt_round_sequencer_byte_round_op.sv
// byte_round_op: one keyed transform applied to a single byte.
// Ports: i_op (op_e), i_byte (8b) -> o_byte (8b); purely combinational.
module byte_round_op
    import crypt_pkg::*;
(
    input  op_e               i_op,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BYTE_W-1:0] o_byte
);

    always_comb begin
        o_byte = i_byte;
        unique case (i_op)
            OP_INV:   o_byte = ~i_byte;
            OP_ROR2:  o_byte = {i_byte[1:0], i_byte[7:2]};
            OP_ROL2:  o_byte = {i_byte[5:0], i_byte[7:6]};
            OP_INVLO: o_byte = {i_byte[7:4], ~i_byte[3:0]};
            default:  o_byte = i_byte;
        endcase
    end

endmodule

// File: rtl/crypt_round_sequencer.sv
// crypt_round_sequencer: runs one 32-bit block through ROUNDS keyed
// byte transforms, one 2-bit key slice per round (MSB slice first).
// Ports: clk, reset (async, active-high), bus (slave: in_valid/
// in_ready/in_block/in_key, out_valid/out_ready/out_block),
// busy (RUN or DONE), round_idx (current round, 0 when idle).
module crypt_round_sequencer
    import crypt_pkg::*;
#(
    parameter int ROUNDS = 5,
    parameter int KEY_W  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    crypt_round_sequencer_if.slave       bus,
    output logic                         busy,
    output logic [$clog2(ROUNDS+1)-1:0]  round_idx
);

    localparam int RW = $clog2(ROUNDS+1);

    state_e             r_state;
    logic [BLOCK_W-1:0] r_data;
    logic [KEY_W-1:0]   r_key;
    logic [RW-1:0]      r_round;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [BLOCK_W-1:0] r_out_block;
    logic               r_busy;

    op_e                w_op;
    logic [BLOCK_W-1:0] w_next;

    // Shift the consumed slices out the top; the next op is the top pair.
    assign w_op = op_e'(2'((r_key << {r_round, 1'b0}) >> (KEY_W - 2)));

    for (genvar g = 0; g < BLOCK_W / BYTE_W; g++) begin : g_byte
        byte_round_op u_op (
            .i_op   (w_op),
            .i_byte (r_data[g*BYTE_W +: BYTE_W]),
            .o_byte (w_next[g*BYTE_W +: BYTE_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_key       <= '0;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_block <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_data     <= bus.in_block;
                        r_key      <= bus.in_key;
                        r_round    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_data  <= w_next;
                    r_round <= r_round + RW'(1);
                    // Result register only ever sees a finished block.
                    if (r_round == RW'(ROUNDS - 1)) begin
                        r_out_block <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_round     <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_block = r_out_block;
    assign busy          = r_busy;
    assign round_idx     = r_round;

endmodule

// File: tb/tb_crypt_round_sequencer.sv
// tb_crypt_round_sequencer: scoreboard bench for the round sequencer.
// Expected blocks are queued at acceptance and popped on each transfer.
module tb_crypt_round_sequencer;
    import crypt_pkg::*;

    localparam int ROUNDS = 5;
    localparam int KEY_W  = 10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [2:0] round_idx;

    crypt_round_sequencer_if #(.KEY_W(KEY_W)) bus ();

    crypt_round_sequencer #(
        .ROUNDS (ROUNDS),
        .KEY_W  (KEY_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    int          n_chk    = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          acc_cyc  = 0;
    int          acc_prev = 0;
    int          xfer_cyc = 0;
    int          n_out    = 0;
    logic        prev_ov  = 1'b0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [31:0] b,
                                          input logic [KEY_W-1:0] k);
        logic [31:0] d;
        d = b;
        for (int r = 0; r < ROUNDS; r++) begin
            logic [1:0] op;
            op = {k[KEY_W-1-2*r], k[KEY_W-2-2*r]};
            for (int i = 0; i < 4; i++) begin
                logic [7:0] x;
                x = d[8*i +: 8];
                case (op)
                    2'd0:    x = ~x;
                    2'd1:    x = {x[1:0], x[7:2]};
                    2'd2:    x = {x[5:0], x[7:6]};
                    default: x = {x[7:4], ~x[3:0]};
                endcase
                d[8*i +: 8] = x;
            end
        end
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_prev = acc_cyc;
                acc_cyc  = cyc;
            end
            if (bus.out_valid && !prev_ov)
                check("latency", 32'(cyc - acc_cyc), 32'd6);
            if (bus.out_valid && bus.out_ready) begin
                xfer_cyc = cyc;
                n_out++;
                if (exp_q.size() == 0)
                    check("spurious_out", bus.out_block, 32'hx);
                else
                    check("out_block", bus.out_block, exp_q.pop_front());
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [31:0] b,
                        input logic [KEY_W-1:0] k,
                        input logic [31:0] e);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_block = b;
        bus.in_key   = k;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0)
            check("drain_timeout", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        logic [31:0] b;
        logic [9:0]  k;

        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 32'd1);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_block", bus.out_block, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_round_idx", round_idx, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        bus.out_ready = 1'b1;
        send(32'h12345678, 10'h000, 32'hEDCBA987);
        wait_drain();
        send(32'h12345678, 10'h155, 32'h840D951E);
        wait_drain();

        send(32'h12345678, 10'b10_01_10_01_11, 32'h1D3B5977);
        for (int r = 0; r < ROUNDS; r++) begin
            @(negedge clk);
            check("run_round_idx", round_idx, r);
            check("run_busy", busy, 32'd1);
        end
        wait_drain();

        bus.out_ready = 1'b0;
        send(32'hA5A50F0F, 10'h2C6, model(32'hA5A50F0F, 10'h2C6));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_block = 32'hCAFEBABE;
        bus.in_key   = 10'h0F3;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 32'd1);
            if (exp_q.size() != 0)
                check("bp_out_block", bus.out_block, exp_q[0]);
            check("bp_in_ready", bus.in_ready, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(32'hCAFEBABE, 10'h0F3, model(32'hCAFEBABE, 10'h0F3));
        check("accept_gap", 32'(acc_cyc - xfer_cyc), 32'd1);
        wait_drain();

        send(32'h13579BDF, 10'h1A5, model(32'h13579BDF, 10'h1A5));
        repeat (3) @(negedge clk);
        check("pre_rst_round", round_idx, 32'd2);
        reset = 1'b1;
        if (exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_in_ready", bus.in_ready, 32'd1);
        check("abort_out_valid", bus.out_valid, 32'd0);
        check("abort_round_idx", round_idx, 32'd0);
        check("abort_busy", busy, 32'd0);
        send(32'h00000000, 10'h3FF, 32'h0F0F0F0F);
        wait_drain();

        n0 = n_out;
        send(32'h01020304, 10'h0B4, model(32'h01020304, 10'h0B4));
        send(32'hF0E0D0C0, 10'h36A, model(32'hF0E0D0C0, 10'h36A));
        wait_drain();
        check("b2b_interval", 32'(acc_cyc - acc_prev), 32'd7);
        check("b2b_count", 32'(n_out - n0), 32'd2);

        for (int i = 0; i < 4; i++) begin
            b = $urandom;
            k = 10'($urandom);
            send(b, k, model(b, k));
        end
        wait_drain();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
